// File: rtl/freq_meter_pkg.sv
// Shared definitions for the gated frequency meter: FSM state encoding and
// default sizing of the gate window and edge counter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_GATE  = 2'd2,
        ST_LATCH = 2'd3
    } state_e;

    localparam int unsigned GATE_CYCLES_DEF = 32'd100000000;
    localparam int unsigned CNT_W_DEF       = 32'd32;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus a third register for rising-edge detection of an
// asynchronous input; the edge pulse is held off until the history register is valid.
module sync_edge_det (
    input  logic Clk,
    input  logic Rst,
    input  logic Async_In,
    output logic Level,
    output logic Rise
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       prev_q,  prev_d;
    logic [2:0] fill_q,  fill_d;

    // Next values of the synchronizer chain and the post-reset fill tracker
    always_comb begin
        sync1_d = Async_In;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        fill_d  = {fill_q[1:0], 1'b1};
    end

    // Synchronizer, history and fill registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            fill_q  <= 3'b000;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            fill_q  <= fill_d;
        end
    end

    // A level that is already high once the chain fills is not a real edge
    assign Level = sync2_q;
    assign Rise  = sync2_q & ~prev_q & fill_q[2];

endmodule

// File: rtl/freq_meter_ctrl.sv
// Gated frequency meter: counts synchronized Fxin rising edges over a fixed
// window of GATE_CYCLES clocks and presents the count with a valid/ack handshake.
module freq_meter_ctrl
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Fxin,
    input  logic             Start,
    input  logic             Continuous,
    input  logic             Freq_Ack,
    output logic             Gate,
    output logic             Busy,
    output logic [CNT_W-1:0] Frequency,
    output logic             Freq_Valid,
    output logic             Overflow,
    output logic             Missed
);

    localparam int unsigned TMR_W = $clog2(GATE_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e             state_q, state_d;
    logic               gate_q, gate_d;
    logic               busy_q, busy_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic [CNT_W-1:0]   freq_q, freq_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;
    logic               missed_q, missed_d;
    logic               fx_rise_s;
    logic               fx_level_unused;

    sync_edge_det u_sync_edge_det (
        .Clk      (Clk),
        .Rst      (Rst),
        .Async_In (Fxin),
        .Level    (fx_level_unused),
        .Rise     (fx_rise_s)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Start outside IDLE is simply not looked at
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (Start || Continuous) begin
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                state_d = ST_GATE;
            end
            ST_GATE: begin
                if (timer_q == TMR_LAST) begin
                    state_d = ST_LATCH;
                end else begin
                    state_d = ST_GATE;
                end
            end
            ST_LATCH: begin
                if (Continuous) begin
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Gate/Busy decoded from the next state so they can be registered
    always_comb begin
        gate_d = (state_d == ST_GATE);
        busy_d = (state_d != ST_IDLE);
    end

    // Gate timer, saturating edge counter and result handshake
    always_comb begin
        timer_d  = timer_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        freq_d   = freq_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        missed_d = missed_q;

        case (state_q)
            ST_ARM: begin
                timer_d = {TMR_W{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
                sat_d   = 1'b0;
            end
            ST_GATE: begin
                timer_d = timer_q + TMR_W'(1);
                if (fx_rise_s) begin
                    if (cnt_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                timer_d = timer_q;
            end
        endcase

        // A latch in the same cycle as an ack counts as consumed, not missed
        if (state_q == ST_LATCH) begin
            freq_d  = cnt_q;
            ovf_d   = sat_q;
            valid_d = 1'b1;
            if (valid_q && !Freq_Ack) begin
                missed_d = 1'b1;
            end else begin
                missed_d = missed_q;
            end
        end else if (Freq_Ack) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if ((state_q == ST_IDLE) && Start) begin
            missed_d = 1'b0;
        end else begin
            missed_d = missed_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            gate_q   <= 1'b0;
            busy_q   <= 1'b0;
            timer_q  <= {TMR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            sat_q    <= 1'b0;
            freq_q   <= {CNT_W{1'b0}};
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            gate_q   <= gate_d;
            busy_q   <= busy_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            freq_q   <= freq_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            missed_q <= missed_d;
        end
    end

    assign Gate       = gate_q;
    assign Busy       = busy_q;
    assign Frequency  = freq_q;
    assign Freq_Valid = valid_q;
    assign Overflow   = ovf_q;
    assign Missed     = missed_q;

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// Directed bench for freq_meter_ctrl: an 8-bit and a 5-bit counter instance
// share stimulus; a vector table covers single measurements, sequences the rest.
module tb_freq_meter_ctrl;

    logic       clk;
    logic       rst;
    logic       fxin;
    logic       start;
    logic       cont;
    logic       ack;

    logic       gate8, busy8, valid8, ovf8, missed8;
    logic [7:0] freq8;
    logic       gate5, busy5, valid5, ovf5, missed5;
    logic [4:0] freq5;

    int tests = 0;
    int fails = 0;
    int gcnt  = 0;
    int fx_half = 0;
    int fx_cnt  = 0;

    typedef struct {
        int         half;
        logic [7:0] f8;
        logic       o8;
        logic [4:0] f5;
        logic       o5;
    } vec_t;

    vec_t vecs [5];

    freq_meter_ctrl #(.GATE_CYCLES(100), .CNT_W(8)) dut8 (
        .Clk(clk), .Rst(rst), .Fxin(fxin), .Start(start), .Continuous(cont),
        .Freq_Ack(ack), .Gate(gate8), .Busy(busy8), .Frequency(freq8),
        .Freq_Valid(valid8), .Overflow(ovf8), .Missed(missed8)
    );

    freq_meter_ctrl #(.GATE_CYCLES(100), .CNT_W(5)) dut5 (
        .Clk(clk), .Rst(rst), .Fxin(fxin), .Start(start), .Continuous(cont),
        .Freq_Ack(ack), .Gate(gate5), .Busy(busy5), .Frequency(freq5),
        .Freq_Valid(valid5), .Overflow(ovf5), .Missed(missed5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fxin source: half-period in clocks, 0 holds low, negative holds high
    initial begin
        fxin = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (fx_half < 0) begin
                fxin = 1'b1;
            end else if (fx_half == 0) begin
                fxin = 1'b0;
            end else begin
                fx_cnt++;
                if (fx_cnt >= fx_half) begin
                    fx_cnt = 0;
                    fxin = ~fxin;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (gate8) gcnt++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // sel: 0 valid, 1 busy, 2 gate, 3 missed
    task automatic wait_sig(input int sel, input logic lvl, input int budget, input string name);
        logic cur;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            case (sel)
                0: cur = valid8;
                1: cur = busy8;
                2: cur = gate8;
                default: cur = missed8;
            endcase
            if (cur == lvl) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; cont = 1'b0; ack = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{half: 5,  f8: 8'd10, o8: 1'b0, f5: 5'd10, o5: 1'b0};
        vecs[1] = '{half: 1,  f8: 8'd50, o8: 1'b0, f5: 5'd31, o5: 1'b1};
        vecs[2] = '{half: 2,  f8: 8'd25, o8: 1'b0, f5: 5'd25, o5: 1'b0};
        vecs[3] = '{half: 0,  f8: 8'd0,  o8: 1'b0, f5: 5'd0,  o5: 1'b0};
        vecs[4] = '{half: 25, f8: 8'd2,  o8: 1'b0, f5: 5'd2,  o5: 1'b0};

        rst = 1'b1; start = 1'b0; cont = 1'b0; ack = 1'b0;
        step();
        step();
        chk("rst_gate",   {31'd0, gate8},   32'd0);
        chk("rst_busy",   {31'd0, busy8},   32'd0);
        chk("rst_freq",   {24'd0, freq8},   32'd0);
        chk("rst_valid",  {31'd0, valid8},  32'd0);
        chk("rst_ovf",    {31'd0, ovf8},    32'd0);
        chk("rst_missed", {31'd0, missed8}, 32'd0);
        chk("rst_freq5",  {27'd0, freq5},   32'd0);
        rst = 1'b0;

        // Ack with nothing valid, in IDLE
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("idle_ack_valid", {31'd0, valid8}, 32'd0);
        chk("idle_ack_busy",  {31'd0, busy8},  32'd0);

        // Single measurements from the vector table
        for (int v = 0; v < 5; v++) begin
            fx_half = vecs[v].half;
            do_reset();
            for (int k = 0; k < 20; k++) step();
            gcnt = 0;
            pulse_start();
            chk($sformatf("v%0d_busy_on", v), {31'd0, busy8}, 32'd1);
            wait_sig(0, 1'b1, 400, $sformatf("v%0d_wait_valid", v));
            chk($sformatf("v%0d_gate_len", v), gcnt, 32'd100);
            chk($sformatf("v%0d_freq8", v), {24'd0, freq8}, {24'd0, vecs[v].f8});
            chk($sformatf("v%0d_ovf8", v),  {31'd0, ovf8},  {31'd0, vecs[v].o8});
            chk($sformatf("v%0d_freq5", v), {27'd0, freq5}, {27'd0, vecs[v].f5});
            chk($sformatf("v%0d_ovf5", v),  {31'd0, ovf5},  {31'd0, vecs[v].o5});
            chk($sformatf("v%0d_valid5", v), {31'd0, valid5}, 32'd1);
            chk($sformatf("v%0d_busy_off", v), {31'd0, busy8}, 32'd0);
            chk($sformatf("v%0d_missed", v), {31'd0, missed8}, 32'd0);
            ack = 1'b1;
            step();
            ack = 1'b0;
            chk($sformatf("v%0d_ack_clr", v), {31'd0, valid8}, 32'd0);
        end

        // Continuous without ack: second latch overwrites and sets Missed
        fx_half = 2;
        do_reset();
        for (int k = 0; k < 20; k++) step();
        cont = 1'b1;
        wait_sig(0, 1'b1, 400, "cont_first_valid");
        chk("cont_first_freq",   {24'd0, freq8},   32'd25);
        chk("cont_first_missed", {31'd0, missed8}, 32'd0);
        chk("cont_rearm_busy",   {31'd0, busy8},   32'd1);
        wait_sig(3, 1'b1, 400, "cont_wait_missed");
        chk("cont_second_freq",  {24'd0, freq8},   32'd25);
        chk("cont_second_valid", {31'd0, valid8},  32'd1);
        cont = 1'b0;
        wait_sig(1, 1'b0, 400, "cont_wait_idle");
        chk("cont_missed_sticky", {31'd0, missed8}, 32'd1);
        pulse_start();
        chk("start_clears_missed", {31'd0, missed8}, 32'd0);
        chk("start_busy",          {31'd0, busy8},   32'd1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        wait_sig(0, 1'b1, 400, "after_clear_valid");
        chk("after_clear_missed", {31'd0, missed8}, 32'd0);

        // Ack on the LATCH cycle: valid stays, no Missed, new value shown
        fx_half = 5;
        do_reset();
        for (int k = 0; k < 20; k++) step();
        pulse_start();
        wait_sig(0, 1'b1, 400, "ackl_first_valid");
        chk("ackl_first_freq", {24'd0, freq8}, 32'd10);
        fx_half = 2;
        for (int k = 0; k < 20; k++) step();
        pulse_start();
        wait_sig(2, 1'b1, 50, "ackl_gate_rise");
        wait_sig(2, 1'b0, 200, "ackl_gate_fall");
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("ackl_valid",  {31'd0, valid8},  32'd1);
        chk("ackl_missed", {31'd0, missed8}, 32'd0);
        chk("ackl_freq",   {24'd0, freq8},   32'd25);
        step();
        chk("ackl_valid_hold", {31'd0, valid8}, 32'd1);

        // Reset in the middle of the gate, then a full restart
        gcnt = 0;
        pulse_start();
        for (int k = 0; k < 200 && gcnt < 50; k++) step();
        chk("midrst_reached", gcnt, 32'd50);
        rst = 1'b1;
        step();
        chk("midrst_gate",   {31'd0, gate8},   32'd0);
        chk("midrst_busy",   {31'd0, busy8},   32'd0);
        chk("midrst_freq",   {24'd0, freq8},   32'd0);
        chk("midrst_valid",  {31'd0, valid8},  32'd0);
        chk("midrst_ovf",    {31'd0, ovf8},    32'd0);
        chk("midrst_missed", {31'd0, missed8}, 32'd0);
        rst = 1'b0;
        step();
        chk("midrst_no_latch", {31'd0, valid8}, 32'd0);
        gcnt = 0;
        pulse_start();
        wait_sig(0, 1'b1, 400, "restart_valid");
        chk("restart_gate_len", gcnt, 32'd100);
        chk("restart_freq", {24'd0, freq8}, 32'd25);
        ack = 1'b1;
        step();
        ack = 1'b0;

        // Start and Ack during GATE are ignored
        gcnt = 0;
        pulse_start();
        for (int k = 0; k < 200 && gcnt < 30; k++) step();
        start = 1'b1;
        ack = 1'b1;
        step();
        start = 1'b0;
        ack = 1'b0;
        chk("midgate_gate",  {31'd0, gate8},  32'd1);
        chk("midgate_busy",  {31'd0, busy8},  32'd1);
        chk("midgate_valid", {31'd0, valid8}, 32'd0);
        wait_sig(0, 1'b1, 400, "midgate_wait_valid");
        chk("midgate_gate_len", gcnt, 32'd100);
        chk("midgate_freq", {24'd0, freq8}, 32'd25);
        step();
        chk("midgate_idle", {31'd0, busy8}, 32'd0);

        // Fxin already high at reset release: no phantom edge
        fx_half = -1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        gcnt = 0;
        wait_sig(0, 1'b1, 400, "high_rel_valid");
        chk("high_rel_freq", {24'd0, freq8}, 32'd0);
        chk("high_rel_gate_len", gcnt, 32'd100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
